ram_3d_reader: RTL

RAM_3D_READER -- requirements
Module: ram_3d_reader

---
 rtl/ram_3d_pkg.sv | 15 +
 rtl/ram_3d_reader_if.sv | 34 +++
 rtl/ram_3d_rd_fifo.sv | 47 ++++
 rtl/ram_3d_reader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ram_3d_pkg.sv
// Shared types and constants for the 3D RAM reader: FSM state encoding and
// read-data FIFO sizing.
package ram_3d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_3d_reader_if.sv
// Request, RAM-bank and output-stream signals of the 3D RAM reader.
// master: the reader itself; slave: the surrounding logic / RAM banks.
interface ram_3d_reader_if #(
    parameter int unsigned RAM_NUM = 10,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDRESS = 10
);

    logic                               start;
    logic [ADDRESS-1:0]                 base_addr;
    logic [ADDRESS:0]                   length;
    logic                               busy;
    logic                               done;
    logic                               err;
    logic [RAM_NUM-1:0]                 ena;
    logic [RAM_NUM-1:0]                 wea;
    logic [RAM_NUM-1:0][ADDRESS-1:0]    addra;
    logic [RAM_NUM-1:0][WIDTH-1:0]      douta;
    logic                               out_valid;
    logic                               out_ready;
    logic [RAM_NUM-1:0][WIDTH-1:0]      out_data;
    logic                               out_last;

    modport master (
        input  start, base_addr, length, douta, out_ready,
        output busy, done, err, ena, wea, addra, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, length, douta, out_ready,
        input  busy, done, err, ena, wea, addra, out_valid, out_data, out_last
    );

endinterface

// File: rtl/ram_3d_rd_fifo.sv
// Two-entry FIFO holding returned bank words plus the last-beat flag.
// The reader's issue credit guarantees push never occurs while full and
// pop only occurs while valid.
module ram_3d_rd_fifo
    import ram_3d_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  valid
);

    logic [FIFO_DEPTH-1:0][W-1:0] mem_q;
    logic [FIFO_PTR_W-1:0]        wr_ptr_q;
    logic [FIFO_PTR_W-1:0]        rd_ptr_q;
    logic [FIFO_CNT_W-1:0]        count_q;

    // Storage, pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            count_q <= count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign valid = (count_q != '0);

endmodule

// File: rtl/ram_3d_reader.sv
// Reads length consecutive words from RAM_NUM banks in lockstep and streams
// them out as ready/valid beats through a 2-entry FIFO.
// Optional feature: define RAM_3D_READER_WRAP_EN to let a request run past the
// top of the address space and wrap to 0; otherwise such requests pulse err.
module ram_3d_reader
    import ram_3d_pkg::*;
#(
    parameter int unsigned RAM_NUM = 10,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDRESS = 10
) (
    input  logic          clk,
    input  logic          rst,
    ram_3d_reader_if.master bus
);

    localparam int unsigned DATA_W = RAM_NUM * WIDTH;
    localparam int unsigned FIFO_W = DATA_W + 1;
    localparam int unsigned LEN_W  = ADDRESS + 1;
`ifndef RAM_3D_READER_WRAP_EN
    localparam int unsigned SUM_W  = ADDRESS + 2;
    localparam logic [SUM_W-1:0] SPAN = SUM_W'(1) << ADDRESS;
`endif

    state_t                 state_q, state_d;
    logic [ADDRESS-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       beat_q, beat_d;
    logic                   inflight_q, inflight_last_q;
    logic                   done_zero_q, err_q;
    logic                   req_ok, req_zero, req_bad;
    logic                   issue, issue_last, pop, drain_done;
    logic [2:0]             occupancy;
    logic [FIFO_CNT_W-1:0]  fifo_count;
    logic [FIFO_W-1:0]      fifo_head;
    logic                   fifo_valid;

    // Request decode, issue credit and last-beat detection.
    always_comb begin
        req_zero   = (state_q == IDLE) && bus.start && (bus.length == '0);
`ifdef RAM_3D_READER_WRAP_EN
        req_bad    = 1'b0;
`else
        req_bad    = (state_q == IDLE) && bus.start && (bus.length != '0) &&
                     ((SUM_W'(bus.base_addr) + SUM_W'(bus.length)) > SPAN);
`endif
        req_ok     = (state_q == IDLE) && bus.start && (bus.length != '0) && !req_bad;
        pop        = fifo_valid && bus.out_ready;
        occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        issue      = (state_q == RUN) && (occupancy < 3'd2);
        issue_last = (beat_q == (len_q - LEN_W'(1)));
        drain_done = (state_q == DRAIN) && pop && fifo_head[FIFO_W-1];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus address / beat counter updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d = RUN;
                    addr_d  = bus.base_addr;
                    len_d   = bus.length;
                    beat_d  = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDRESS'(1);
                    beat_d = beat_q + LEN_W'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: counters, read-in-flight tracking, pulse sources.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q          <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_zero_q     <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;
            done_zero_q     <= req_zero;
            err_q           <= req_bad;
        end
    end

    ram_3d_rd_fifo #(
        .W (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   ({inflight_last_q, bus.douta}),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .valid (fifo_valid)
    );

    // Outputs forced to zero while reset is asserted.
    assign bus.busy      = rst && (state_q != IDLE);
    assign bus.done      = rst && (done_zero_q || drain_done);
    assign bus.err       = rst && err_q;
    assign bus.ena       = {RAM_NUM{rst && issue}};
    assign bus.wea       = '0;
    assign bus.out_valid = rst && fifo_valid;
    assign bus.out_last  = rst && fifo_head[FIFO_W-1];
    assign bus.out_data  = rst ? fifo_head[DATA_W-1:0] : '0;

    // Every bank sees the same address.
    always_comb begin
        bus.addra = '0;
        for (int i = 0; i < RAM_NUM; i++) begin
            bus.addra[i] = rst ? addr_q : '0;
        end
    end

endmodule
